ram_4x1_array: RTL and testbench

//  - 4-word x 1-bit single-port RAM: synchronous write, asynchronous (combinational) read.
//  - Small scratch/flag store for control logic.
//  - One shared address for read and write.
//  - Storage is a register array cleared by reset; no vendor memory macro.

---
 rtl/ram_4x1_pkg.sv | 12 +
 rtl/ram_4x1_wdec.sv | 23 ++
 rtl/ram_4x1_array.sv | 56 +++++
 tb/tb_ram_4x1_array.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_4x1_pkg.sv
// Shared sizing and types for the 4x1 scratch RAM.
// The top-level build option is the macro RAM_4X1_ARRAY_REG_OUT_EN (see ram_4x1_array).
package ram_4x1_pkg;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ram_4x1_wdec.sv
// One-hot write-enable decoder for the 4x1 RAM: at most one word load enable,
// and only while the write enable is high.
module ram_4x1_wdec
  import ram_4x1_pkg::*;
(
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DEPTH-1:0]  o_wen
);

  // An unknown address compares false everywhere, so no word gets loaded.
  always_comb begin
    o_wen = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (i_we && (i_addr == ADDR_W'(k))) begin
        o_wen[k] = 1'b1;
      end else begin
        o_wen[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_4x1_array.sv
// 4-word x 1-bit single-port RAM: synchronous write, combinational read.
// Build option RAM_4X1_ARRAY_REG_OUT_EN registers dout (1-cycle read-before-write latency).
module ram_4x1_array
  import ram_4x1_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             w_wen;
  logic [DATA_W-1:0]            w_rd_word;

  ram_4x1_wdec u_wdec (
    .i_we   (i_we),
    .i_addr (i_addr),
    .o_wen  (w_wen)
  );

  // Per-word storage; reset clears every word without waiting for a clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem <= {(DEPTH*DATA_W){1'b0}};
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_wen[k]) begin
          r_mem[k] <= i_din;
        end
      end
    end
  end

  assign w_rd_word = r_mem[i_addr];

`ifdef RAM_4X1_ARRAY_REG_OUT_EN
  logic [DATA_W-1:0] r_dout;

  // Samples the pre-write word, so a same-address write shows up one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout <= {DATA_W{1'b0}};
    end else begin
      r_dout <= w_rd_word;
    end
  end

  assign o_dout = r_dout;
`else
  assign o_dout = w_rd_word;
`endif

endmodule

// File: tb/tb_ram_4x1_array.sv
// Self-checking bench for ram_4x1_array: directed vector table, hand sequences
// for reset/read-during-write corners, and randomized traffic against an array model.
module tb_ram_4x1_array;

  logic       clk;
  logic       rst;
  logic       we;
  logic [1:0] addr;
  logic       din;
  logic       dout;

  int checks;
  int failures;

  logic model [4];
  logic exp_reg;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic       din;
    logic       exp_comb;
    logic       exp_reg;
  } vec_t;

  vec_t vecs [17];

  ram_4x1_array dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (we),
    .i_addr (addr),
    .i_din  (din),
    .o_dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: dout=%0b expected=%0b (addr=%0d we=%0b t=%0t)", nm, act, expv, addr, we, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model[i] = 1'b0;
    exp_reg = 1'b0;
  endtask

  task automatic check_model(input string nm);
    logic e;
`ifdef RAM_4X1_ARRAY_REG_OUT_EN
    e = exp_reg;
`else
    e = model[addr];
`endif
    if (rst) e = 1'b0;
    chk(nm, dout, e);
  endtask

  // Advance one rising edge, applying the memory rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      exp_reg = model[addr];
      if (we) model[addr] = din;
    end
    #1;
  endtask

  task automatic op(input logic we_v, input logic [1:0] a, input logic d, input string nm);
    we = we_v; addr = a; din = d;
    #2;
    check_model(nm);
    step();
  endtask

  task automatic pulse_rst(input string nm);
    rst = 1'b1;
    model_clear();
    #1;
    chk(nm, dout, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // {we, addr, din, expected dout before the edge: combinational, registered}
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; we = 1'b0; addr = 2'd0; din = 1'b0;
    model_clear();
    step();
    step();
    rst = 1'b0;
    #2;
    chk("reset_state", dout, 1'b0);

    // Fill with ones, then clear asynchronously between edges.
    for (int k = 0; k < 4; k++) op(1'b1, 2'(k), 1'b1, "fill_ones");
    op(1'b0, 2'd2, 1'b0, "fill_readback");
    op(1'b0, 2'd2, 1'b0, "fill_readback2");
    pulse_rst("rst_async_dout");
    for (int k = 0; k < 4; k++) begin
      we = 1'b0; addr = 2'(k); din = 1'b1;
      #1;
      chk("reset_sweep", dout, 1'b0);
      step();
    end

    for (int i = 0; i < 17; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      #2;
`ifdef RAM_4X1_ARRAY_REG_OUT_EN
      chk($sformatf("vec%0d", i), dout, vecs[i].exp_reg);
`else
      chk($sformatf("vec%0d", i), dout, vecs[i].exp_comb);
`endif
      step();
    end

    // Read-during-write at address 3.
    op(1'b1, 2'd3, 1'b0, "rdw_prep");
    op(1'b1, 2'd3, 1'b0, "rdw_prep2");
    we = 1'b1; addr = 2'd3; din = 1'b1;
    #2;
    chk("rdw_before_edge", dout, 1'b0);
    step();
`ifdef RAM_4X1_ARRAY_REG_OUT_EN
    chk("rdw_after_edge", dout, 1'b0);
`else
    chk("rdw_after_edge", dout, 1'b1);
`endif
    step();
    chk("rdw_next_cycle", dout, 1'b1);

    // Write attempted while reset is held, release between edges.
    rst = 1'b1; we = 1'b1; addr = 2'd1; din = 1'b1;
    model_clear();
    step();
    #2;
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst_hold_nowrite", dout, 1'b0);
    step();
    op(1'b0, 2'd1, 1'b0, "rst_hold_read");
    op(1'b1, 2'd1, 1'b1, "release_first_write");
    op(1'b0, 2'd1, 1'b0, "release_read1");
    op(1'b0, 2'd1, 1'b0, "release_read2");
    chk("release_written", dout, 1'b1);

    // Random traffic with mid-cycle address changes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) pulse_rst("rand_rst");
      we = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      din = 1'($urandom_range(0, 1));
      #2;
      check_model("rand_pre");
      addr = 2'($urandom_range(0, 3));
      #2;
      check_model("rand_addr_change");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
